background_line_fetch: RTL and testbench
========================================

Name: background_line_fetch

Overview:
- Read-side client for the 1-bit background bitmap ROM (128x128, synchronous read, 1-cycle latency).
- Prefetches one scaled image row per display line into a ping-pong line buffer.
- Serves a per-pixel foreground bit to the colour mapper from DrawX.
- Sits between the VGA controller and the background ROM, replacing direct per-pixel ROM addressing.

Parameters:
- IMG_W, 128, image width in pixels; power of two.
- IMG_H, 128, image height in rows.
- ADDR_W, 15, ROM address width.
- X_SHIFT, 2, horizontal scale (each image pixel spans 2^X_SHIFT screen pixels).
- Y_SHIFT, 2, vertical scale.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- line_start  in  1  one-cycle pulse at start of each displayed line.
- fetch_y  in  10  screen row to prefetch, sampled with line_start.
- DrawX  in  10  current screen column.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  1  ROM data, valid one Clk after rom_addr.
- pixel_on  out  1  background bit for DrawX.
- fetch_busy  out  1  high while a row fetch is in flight.
- overrun  out  1  sticky: line_start arrived while busy.

Behaviour:
- Reset (async, Reset_n low): state IDLE; rom_addr=0; pixel_on=0; fetch_busy=0; overrun=0; both buffer banks cleared; front bank index=0.
- Interface: one clock; reset is asynchronous and active-low.
- Buffer: two banks of IMG_W bits. Front bank is read for display; back bank is written by the fetch.
- Swap: every line_start toggles front/back unconditionally, then launches a fetch of row r = fetch_y >> Y_SHIFT into the new back bank.
- FSM states:
  - IDLE: on line_start, if r < IMG_H go FETCH with col=0; else go CLEAR.
  - FETCH: each cycle rom_addr = {r, col} (r*IMG_W + col, zero-extended to ADDR_W); col++. After col = IMG_W-1 is issued, go DRAIN.
  - DRAIN: one cycle to capture the final bit, then IDLE.
  - CLEAR: write 0 to all back-bank bits in one cycle, then IDLE.
- Write path: rom_data is written to back[col_d], where col_d is col delayed one cycle. It is written only when the delayed fetch-valid is set.
- Fetch length: IMG_W+1 cycles (IMG_W+2 including the IDLE launch). fetch_busy is high in FETCH, DRAIN and CLEAR.
- Overrun: line_start in any non-IDLE state sets overrun. The in-flight fetch is abandoned, the swap still occurs, and the new fetch restarts at col=0. The partially written bank becomes front.
- overrun clears only on reset.
- Display: pixel_on is registered, one-cycle latency from DrawX.
  - pixel_on = front[DrawX >> X_SHIFT] when (DrawX >> X_SHIFT) < IMG_W; else 0.
- Reset mid-fetch: all state clears immediately. No ROM read is assumed outstanding after reset deassert.

Optional Feature:
- Macro: BG_FETCH_TILE_EN.
- Defined: image tiles.
  - Column index = (DrawX >> X_SHIFT) mod IMG_W.
  - Row = (fetch_y >> Y_SHIFT) mod IMG_H.
  - The CLEAR state is unreachable and omitted.
- Undefined: out-of-range columns give pixel_on=0; out-of-range rows load an all-zero bank via CLEAR.

Decomposition:
- Package bg_fetch_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, CLEAR);
  - default geometry constants (IMG_W, IMG_H, scale shifts);
  - derived COL_W = $clog2(IMG_W).
- Sub-module bg_line_buffer: two-bank IMG_W x 1 storage with a bank-select toggle, one write port, a registered read port, and a clear-bank input.

Test Plan:
- Reset, then line_start with fetch_y=8 -> rom_addr steps 256..383 on consecutive cycles; fetch_busy high for 129 cycles; overrun=0.
- Second line_start, then DrawX=0..511 with ROM row 2 = alternating 1010… -> pixel_on toggles every 4 DrawX, one cycle after DrawX.
- DrawX=600 -> pixel_on=0 one cycle later (tile off). With BG_FETCH_TILE_EN, DrawX=600 (col 150 mod 128 = 22) -> pixel_on = row bit 22.
- fetch_y=520 (row 130 >= 128) -> CLEAR, no ROM addresses beyond 16383. After the swap, pixel_on=0 for all DrawX.
- line_start 40 cycles into a fetch -> overrun=1 and stays 1; new fetch restarts at col 0 of the new row.
- Reset_n asserted mid-FETCH -> rom_addr, pixel_on and fetch_busy go to 0 asynchronously. After release, a fresh line_start fetches correctly.

Source files
------------

// File: rtl/bg_fetch_pkg.sv
// Shared types and default geometry for the background line fetcher.
// The optional BG_FETCH_TILE_EN build never enters CLEAR.
package bg_fetch_pkg;

    localparam int DEF_IMG_W   = 128;
    localparam int DEF_IMG_H   = 128;
    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_X_SHIFT = 2;
    localparam int DEF_Y_SHIFT = 2;
    localparam int COL_W       = $clog2(DEF_IMG_W);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        CLEAR
    } state_t;

endpackage

// File: rtl/bg_line_buffer.sv
// Two-bank single-bit line buffer: front bank read for display,
// back bank written by the fetcher or cleared in one cycle.
module bg_line_buffer #(
    parameter int W  = 128,
    parameter int CW = $clog2(W)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          swap,
    input  logic          we,
    input  logic [CW-1:0] wr_idx,
    input  logic          wr_bit,
    input  logic          clr,
    input  logic          rd_en,
    input  logic [CW-1:0] rd_idx,
    output logic          rd_bit
);

    logic [W-1:0] bank0;
    logic [W-1:0] bank1;
    logic         sel;

    // sel names the front bank; the other bank is the write target
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bank0  <= '0;
            bank1  <= '0;
            sel    <= 1'b0;
            rd_bit <= 1'b0;
        end else begin
            if (swap)
                sel <= ~sel;
            if (we) begin
                if (sel)
                    bank0[wr_idx] <= wr_bit;
                else
                    bank1[wr_idx] <= wr_bit;
            end
            if (clr) begin
                if (sel)
                    bank0 <= '0;
                else
                    bank1 <= '0;
            end
            rd_bit <= rd_en & (sel ? bank1[rd_idx] : bank0[rd_idx]);
        end
    end

endmodule

// File: rtl/background_line_fetch.sv
// Prefetches one scaled bitmap row per display line into a ping-pong buffer.
// Define BG_FETCH_TILE_EN to wrap rows and columns so the image tiles.
module background_line_fetch
    import bg_fetch_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int X_SHIFT = DEF_X_SHIFT,
    parameter int Y_SHIFT = DEF_Y_SHIFT
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              line_start,
    input  logic [9:0]        fetch_y,
    input  logic [9:0]        DrawX,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic              pixel_on,
    output logic              fetch_busy,
    output logic              overrun
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] wcol_q;
    logic          vld_q;
    logic          clr;
    logic          rd_en;
    logic [9:0]    r_full;
    logic [9:0]    dcol;
    logic [RW-1:0] r_row;

    assign r_full = fetch_y >> Y_SHIFT;
    assign dcol   = DrawX >> X_SHIFT;

`ifdef BG_FETCH_TILE_EN
    assign r_row = RW'(32'(r_full) % IMG_H);
    assign rd_en = 1'b1;
`else
    logic r_ok;
    assign r_ok  = 32'(r_full) < IMG_H;
    assign r_row = RW'(r_full);
    assign rd_en = 32'(dcol) < IMG_W;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        clr     = 1'b0;
        if (line_start) begin
            col_d = '0;
`ifdef BG_FETCH_TILE_EN
            row_d   = r_row;
            state_d = FETCH;
`else
            if (r_ok) begin
                row_d   = r_row;
                state_d = FETCH;
            end else begin
                state_d = CLEAR;
            end
`endif
        end else begin
            unique case (state_q)
                FETCH: begin
                    col_d = col_q + 1'b1;
                    if (col_q == CW'(IMG_W - 1))
                        state_d = DRAIN;
                end
                DRAIN: state_d = IDLE;
`ifndef BG_FETCH_TILE_EN
                CLEAR: begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // a restart drops the write of the abandoned row's last issued read
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            wcol_q  <= '0;
            vld_q   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wcol_q  <= col_q;
            vld_q   <= (state_q == FETCH) && !line_start;
            if (line_start && state_q != IDLE)
                overrun <= 1'b1;
        end
    end

    assign rom_addr   = ADDR_W'({row_q, col_q});
    assign fetch_busy = state_q != IDLE;

    bg_line_buffer #(
        .W  (IMG_W),
        .CW (CW)
    ) u_buf (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .swap    (line_start),
        .we      (vld_q),
        .wr_idx  (wcol_q),
        .wr_bit  (rom_data),
        .clr     (clr),
        .rd_en   (rd_en),
        .rd_idx  (dcol[CW-1:0]),
        .rd_bit  (pixel_on)
    );

endmodule

// File: tb/tb_background_line_fetch.sv
// Self-checking bench for background_line_fetch with a 128x128 ROM model.
// Builds with or without BG_FETCH_TILE_EN.
module tb_background_line_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  fetch_y = '0;
    logic [9:0]  DrawX = '0;
    logic [14:0] rom_addr;
    logic        rom_data = 1'b0;
    logic        pixel_on;
    logic        fetch_busy;
    logic        overrun;

    int n_chk = 0;
    int n_fail = 0;

    bit rom [16384];

    background_line_fetch dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .line_start (line_start),
        .fetch_y    (fetch_y),
        .DrawX      (DrawX),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pixel_on   (pixel_on),
        .fetch_busy (fetch_busy),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom[rom_addr[13:0]];

    typedef struct {
        int fy;
        int x;
        bit exp_flat;
        bit exp_tile;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic launch(input int fy);
        fetch_y    = 10'(fy);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fetch_busy && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    // front bank then holds image row of fy; fy=8 is just a dummy swap
    task automatic load_row(input int fy);
        launch(fy);
        wait_idle();
        launch(8);
        wait_idle();
    endtask

    function automatic bit model_pix(input int fy, input int x);
        int r = fy / 4;
        int c = x / 4;
`ifdef BG_FETCH_TILE_EN
        r = r % 128;
        c = c % 128;
`else
        if (r >= 128 || c >= 128) return 1'b0;
`endif
        return rom[r * 128 + c];
    endfunction

    task automatic pix_check(input string name, input int fy, input int x);
        DrawX = 10'(x);
        tick();
        chk(name, 32'(pixel_on), 32'(model_pix(fy, x)));
    endtask

    initial begin
        int cnt;
        bit hi_addr;
        for (int i = 0; i < 16384; i++) rom[i] = 1'($urandom);
        for (int c = 0; c < 128; c++) rom[256 + c] = (c % 2 == 0);

        vecs[0] = '{8,   0,   1'b1, 1'b1};
        vecs[1] = '{8,   3,   1'b1, 1'b1};
        vecs[2] = '{8,   4,   1'b0, 1'b0};
        vecs[3] = '{8,   8,   1'b1, 1'b1};
        vecs[4] = '{8,   508, 1'b0, 1'b0};
        vecs[5] = '{8,   600, 1'b0, 1'b1};
        vecs[6] = '{520, 0,   1'b0, 1'b1};
        vecs[7] = '{520, 600, 1'b0, 1'b1};
        vecs[8] = '{520, 4,   1'b0, 1'b0};

        repeat (3) tick();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_pixel_on", 32'(pixel_on), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        Reset_n = 1'b1;
        tick();

        // row 2 fetch: addresses 256..383, busy for 129 cycles
        launch(8);
        cnt = 0;
        for (int k = 0; k < 128; k++) begin
            chk($sformatf("addr_%0d", k), 32'(rom_addr), 32'(256 + k));
            if (fetch_busy) cnt++;
            tick();
        end
        while (fetch_busy && cnt < 400) begin
            cnt++;
            tick();
        end
        chk("busy_cycles", 32'(cnt), 32'd129);
        chk("no_overrun", 32'(overrun), 32'd0);

        launch(12);
        for (int x = 0; x < 512; x++)
            pix_check($sformatf("sweep_x%0d", x), 8, x);
        DrawX = 10'd600;
        tick();
`ifdef BG_FETCH_TILE_EN
        chk("x600_tile", 32'(pixel_on), 32'd1);
`else
        chk("x600_off", 32'(pixel_on), 32'd0);
`endif
        wait_idle();

        for (int i = 0; i < 9; i++) begin
            load_row(vecs[i].fy);
            DrawX = 10'(vecs[i].x);
            tick();
`ifdef BG_FETCH_TILE_EN
            chk($sformatf("vec%0d", i), 32'(pixel_on), 32'(vecs[i].exp_tile));
`else
            chk($sformatf("vec%0d", i), 32'(pixel_on), 32'(vecs[i].exp_flat));
`endif
        end

        // out-of-range row: no ROM address past 16383, all-zero front
        launch(520);
        cnt = 0;
        hi_addr = 1'b0;
        while (fetch_busy && cnt < 400) begin
            if (rom_addr[14]) hi_addr = 1'b1;
            cnt++;
            tick();
        end
        chk("clr_addr_range", 32'(hi_addr), 32'd0);
`ifdef BG_FETCH_TILE_EN
        chk("clr_busy_cycles", 32'(cnt), 32'd129);
`else
        chk("clr_busy_cycles", 32'(cnt), 32'd1);
`endif
        launch(8);
        wait_idle();
        for (int j = 0; j < 16; j++)
            pix_check("row130_pix", 520, int'($urandom_range(0, 1023)));

        for (int it = 0; it < 6; it++) begin
            int fy = int'($urandom_range(0, 1023));
            load_row(fy);
            for (int j = 0; j < 24; j++)
                pix_check($sformatf("rand_fy%0d", fy), fy,
                          int'($urandom_range(0, 1023)));
        end

        // overrun: restart 40 cycles into a fetch
        launch(8);
        repeat (40) tick();
        chk("pre_overrun_addr", 32'(rom_addr), 32'd296);
        launch(16);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("restart_addr0", 32'(rom_addr), 32'd512);
        tick();
        chk("restart_addr1", 32'(rom_addr), 32'd513);
        wait_idle();
        launch(8);
        wait_idle();
        for (int j = 0; j < 24; j++)
            pix_check("post_overrun_pix", 16, int'($urandom_range(0, 511)));
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // async reset mid-fetch
        launch(8);
        repeat (20) tick();
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_rom_addr", 32'(rom_addr), 32'd0);
        chk("arst_busy", 32'(fetch_busy), 32'd0);
        chk("arst_pixel_on", 32'(pixel_on), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        DrawX = 10'd0;
        tick();
        chk("arst_bank_clear", 32'(pixel_on), 32'd0);
        load_row(8);
        for (int x = 0; x < 64; x++)
            pix_check("post_rst_pix", 8, x * 8 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
